// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   Parametrised UART transmitter. A word is accepted on a valid/ready
//   handshake, latched into a shift register and serialised as
//   start(0) / DATA_BITS data bits LSB first / optional parity / STOP_BITS
//   stop bits(1). Each bit lasts BAUD_DIV clk cycles.
//
//   Optional build macro: UART_TX_FIFO_EN
//     When defined, a FIFO_DEPTH-entry FIFO buffers words in front of the
//     serialiser. tx_ready then means "FIFO not full".
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   [DATA_BITS] word to send
//   tx_valid  in   tx_data is valid
//   tx_ready  out  a word can be accepted this cycle
//   tx        out  registered serial line, idle high
//   busy      out  frame in progress (or FIFO non-empty with the FIFO built)
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int BAUD_DIV    = 5208,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Reject illegal configurations at elaboration.
    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_frame: illegal parameter value");
    end

    state_t                 r_state,    w_state_nxt;
    logic [BAUD_W-1:0]      r_baud_cnt, w_baud_nxt;
    logic [BIT_W-1:0]       r_bit_cnt,  w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift,    w_shift_nxt;
    logic                   r_par,      w_par_nxt;
    logic                   r_tx,       w_tx_bit;
    logic                   r_en;

    logic                   w_baud_last;
    logic                   w_data_last;
    logic                   w_stop_last;
    logic                   w_ser_free;
    logic                   w_load;
    logic [DATA_BITS-1:0]   w_load_data;
    logic                   w_par_in;

    // tx_ready must stay low while reset is asserted and rise on the first
    // edge after release, so the ready path is gated by this flag.
    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_en <= 1'b0;
        else        r_en <= 1'b1;
    end

    assign w_baud_last = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign w_data_last = (r_bit_cnt  == BIT_W'(DATA_BITS - 1));
    assign w_stop_last = (r_bit_cnt  == BIT_W'(STOP_BITS - 1));

    // Serialiser can take a new word in IDLE, or in the very last cycle of
    // the final stop bit so back-to-back frames have no idle gap.
    assign w_ser_free = r_en && ((r_state == S_IDLE) ||
                                 (r_state == S_STOP && w_baud_last && w_stop_last));

    // odd -> ~^data, even -> ^data
    assign w_par_in = (PARITY_MODE == 1) ? ~^w_load_data : ^w_load_data;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;   // one extra bit distinguishes full from empty
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_push;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign tx_ready     = r_en & ~w_fifo_full;
    assign w_push       = tx_valid & tx_ready;
    assign w_load       = w_ser_free & ~w_fifo_empty;
    assign w_load_data  = r_mem[r_rd_ptr];
    assign busy         = (r_state != S_IDLE) | ~w_fifo_empty;

    // NOTE: the storage array is deliberately not reset; clearing the
    // pointers and count is what makes the FIFO empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_load};
        end
    end
`else
    assign tx_ready    = w_ser_free;
    assign w_load      = w_ser_free & tx_valid;
    assign w_load_data = tx_data;
    assign busy        = (r_state != S_IDLE);
`endif

    // Next-state logic. w_tx_bit is the line level of the current state; it
    // is registered into r_tx, so tx lags the state by one edge and the start
    // bit appears on the edge after the transfer.
    // NOTE: every variable gets a default before the case so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_last ? '0 : r_baud_cnt + 1'b1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_bit    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
            end
            S_START: begin
                w_tx_bit = 1'b0;
                if (w_baud_last) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                w_tx_bit = r_shift[0];
                if (w_baud_last) begin
                    w_shift_nxt = r_shift >> 1;
                    if (w_data_last) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_tx_bit = r_par;
                if (w_baud_last) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                end
            end
            S_STOP: begin
                w_tx_bit = 1'b1;
                if (w_baud_last) begin
                    if (w_stop_last) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A new word overrides the end-of-frame transition; the baud counter
        // restarts at 0 so the start bit is phase-locked to the transfer.
        if (w_load) begin
            w_state_nxt = S_START;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = w_load_data;
            w_par_nxt   = w_par_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_bit;
        end
    end

    assign tx = r_tx;

endmodule
